// File: rtl/formula_reorder_collector_pkg.sv
// Shared constants and elaboration helpers for the reorder collector.
// Ports: none (package only).
// Tag width is intentionally not defined here; it derives from DEPTH inside the module.
package formula_reorder_collector_pkg;

    localparam int FRC_DEFAULT_DEPTH = 8;
    localparam int FRC_DEFAULT_WIDTH = 32;

    // Slot pointers wrap by natural overflow, so DEPTH must be a power of two.
    function automatic bit frc_is_pow2(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/formula_reorder_collector.sv
// Reorder collector: hands out tags in order, accepts out-of-order results, retires them in order.
// Ports: clk/rst; alloc_vld/alloc_rdy/alloc_tag (issue side); in_vld/in_tag/in_data (result side);
//        out_vld/out_data (in-order result, 1-cycle latency, no backpressure); err (sticky violation flag).
module formula_reorder_collector
    import formula_reorder_collector_pkg::*;
#(
    parameter int DEPTH = FRC_DEFAULT_DEPTH,
    parameter int WIDTH = FRC_DEFAULT_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alloc_vld,
    output logic                     alloc_rdy,
    output logic [$clog2(DEPTH)-1:0] alloc_tag,
    input  logic                     in_vld,
    input  logic [$clog2(DEPTH)-1:0] in_tag,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     out_vld,
    output logic [WIDTH-1:0]         out_data,
    output logic                     err
);

    localparam int TW = $clog2(DEPTH);
    localparam int CW = TW + 1;

    if (!frc_is_pow2(DEPTH)) begin : g_depth_check
        $error("formula_reorder_collector: DEPTH must be a power of two >= 2");
    end

    logic [TW-1:0]    head;
    logic [TW-1:0]    tail;
    logic [CW-1:0]    count;
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] filled;
    logic [WIDTH-1:0] mem [DEPTH];

    logic             accept;
    logic             in_ok;
    logic             bypass;
    logic             retire;
    logic             err_set;
    logic [DEPTH-1:0] busy_nxt;
    logic [DEPTH-1:0] filled_nxt;
    logic [CW-1:0]    count_nxt;

    // Full is judged on the registered count only, so a same-cycle retirement
    // never opens the door in that cycle.
    assign alloc_rdy = (count != CW'(DEPTH));
    assign alloc_tag = tail;
    assign accept    = alloc_vld && alloc_rdy;

    // A result is legal for an allocated, unfilled slot, or for the slot being
    // allocated this very cycle (which was free at cycle start).
    assign in_ok   = in_vld && ((busy[in_tag] && !filled[in_tag]) ||
                                (accept && (in_tag == tail)));
    // Head result arriving now retires straight from the input.
    assign bypass  = in_ok && (in_tag == head);
    assign retire  = filled[head] || bypass;
    assign err_set = (alloc_vld && !alloc_rdy) || (in_vld && !in_ok);

    always_comb begin
        busy_nxt   = busy;
        filled_nxt = filled;
        count_nxt  = count;
        if (accept) begin
            busy_nxt[tail] = 1'b1;
        end
        if (in_ok && !bypass) begin
            filled_nxt[in_tag] = 1'b1;
        end
        // Clear after set: with an empty collector the head slot can be
        // allocated, filled and retired in the same cycle.
        if (retire) begin
            busy_nxt[head]   = 1'b0;
            filled_nxt[head] = 1'b0;
        end
        case ({accept, retire})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            busy     <= '0;
            filled   <= '0;
            out_vld  <= 1'b0;
            out_data <= '0;
            err      <= 1'b0;
        end else begin
            busy    <= busy_nxt;
            filled  <= filled_nxt;
            count   <= count_nxt;
            out_vld <= retire;
            if (accept) begin
                tail <= tail + TW'(1);
            end
            if (retire) begin
                head     <= head + TW'(1);
                out_data <= filled[head] ? mem[head] : in_data;
            end
            if (err_set) begin
                err <= 1'b1;
            end
        end
    end

    // Result storage carries no reset; validity lives in the filled flags.
    always_ff @(posedge clk) begin
        if (in_ok) begin
            mem[in_tag] <= in_data;
        end
    end

endmodule

// File: doc/formula_reorder_collector.md
FORMULA_REORDER_COLLECTOR -- requirements
Module: formula_reorder_collector

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of outstanding tasks (power of 2, >= 2).
REQ-002 SHALL have parameter WIDTH, default 32, result data width.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port alloc_vld  input  1  distributor issues one task this cycle.
REQ-006 SHALL have port alloc_rdy  output  1  a free slot exists (occupancy < DEPTH).
REQ-007 SHALL have port alloc_tag  output  $clog2(DEPTH)  tag assigned to a task accepted this cycle.
REQ-008 SHALL have port in_vld  input  1  a worker returns a result.
REQ-009 SHALL have port in_tag  input  $clog2(DEPTH)  tag of the returned result.
REQ-010 SHALL have port in_data  input  WIDTH  returned result value.
REQ-011 SHALL have port out_vld  output  1  in-order result valid (one-cycle pulse per result, no backpressure).
REQ-012 SHALL have port out_data  output  WIDTH  in-order result value.
REQ-013 SHALL have port err  output  1  sticky protocol-violation flag.

Function
REQ-014 SHALL accept a task when alloc_vld && alloc_rdy; alloc_tag SHALL equal the tail pointer; the tail then increments modulo DEPTH.
REQ-015 SHALL ignore alloc_vld while alloc_rdy=0, with no state change and err set.
REQ-016 SHALL store in_data into slot in_tag and mark it filled when in_vld=1 and the slot is allocated and unfilled.
REQ-017 SHALL ignore in_vld for an unallocated or already-filled slot and set err.
REQ-018 SHALL retire at most one result per cycle, always the head slot, in allocation order.
REQ-019 SHALL assert out_vld with out_data registered in cycle t+1 when the head slot is filled in cycle t, or when in_vld with in_tag==head arrives in cycle t (input bypass; no extra cycle).
REQ-020 On retirement, SHALL free the head slot, clear its filled flag, and increment head modulo DEPTH.
REQ-021 SHALL keep the occupancy counter 0..DEPTH; simultaneous accept and retire SHALL leave it unchanged.
REQ-022 SHALL deassert alloc_rdy combinationally when occupancy==DEPTH; a retirement in the same cycle SHALL NOT make alloc_rdy high in that cycle.
REQ-023 SHALL allow allocation and result into the same slot in one cycle only if the slot was free at cycle start; otherwise, REQ-017 applies.
REQ-024 SHALL retain out_data after out_vld falls; out_vld=0 SHALL hold out_data unchanged.
REQ-025 SHALL handle head/tail pointer wrap-around transparently; results for slots DEPTH-1 then 0 SHALL emerge in that order.

Reset
REQ-026 SHALL, on rst=1 at any time including mid-operation, immediately clear head, tail, occupancy, all filled flags, out_vld, out_data, and err to 0, with alloc_rdy=1.
REQ-027 SHALL discard all in-flight tasks on reset; results arriving after reset for old tags SHALL set err.
REQ-028 SHALL leave the result storage array without reset.

Structure
REQ-029 SHALL place no tag typedef in a shared package; tag width derives locally from DEPTH.
REQ-030 SHALL be a single module with no sub-module; storage is a register array plus filled-flag vector.

Verification (bench DEPTH=4, WIDTH=32)
REQ-031 Sequence: allocate 4 tasks (tags 0..3), return results in order 2,0,3,1 with data 20,10,30,11 -> out_vld pulses emit 10 (cycle after tag 0 returns), then 11, 20, 30 on consecutive cycles after tag 1 returns.
REQ-032 Full: allocate 4 tasks, then drive alloc_vld=1 -> alloc_rdy=0, the 5th request is ignored, err=1; after one retirement, alloc_rdy=1 and the next alloc_tag=0.
REQ-033 Bypass: with one outstanding tag 0, drive in_vld, in_tag=0, in_data=7 in cycle t -> out_vld=1, out_data=7 in cycle t+1; occupancy returns to 0.
REQ-034 Simultaneous: at occupancy 2, accept one allocation while head retires -> occupancy stays 2; 12 tasks with in-order returns wrap the pointers 3 times with no loss.
REQ-035 Errors: return tag 2 unallocated, or tag 0 twice -> err=1 sticky, output order unaffected.
REQ-036 Reset mid-flight: 3 outstanding with 1 filled, assert rst -> out_vld=0, alloc_rdy=1, err=0 at once; the next allocation gets tag 0.
